// File: rtl/ubc_pkg.sv
// Shared encodings and default widths for the universal range counter.
// Pure declarations: no logic, no latency.
package ubc_pkg;

    localparam int UBC_N_DEF       = 11;
    localparam int UBC_STEP_W_DEF  = 4;
    localparam int UBC_PRESC_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } ubc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ubc_state_e;

endpackage

// File: rtl/ubc_prescaler.sv
// Divider cycling 0..div while en is high; tick marks the last phase. Built only with UBC_PRESCALE_EN.
// Latency: tick is combinational from the registered phase; no backpressure, clr restarts the phase.
module ubc_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // >= lets the phase recover at once if div is lowered mid-count
            cnt_d = (cnt_q >= div) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/univ_range_counter.sv
// Windowed up/down counter with wrap/saturate/one-shot end handling; optional prescaler via UBC_PRESCALE_EN.
// Latency: one clock from qualified input to q; no backpressure, inputs are sampled every cycle.
module univ_range_counter
    import ubc_pkg::*;
#(
    parameter int N       = UBC_N_DEF,
    parameter int STEP_W  = UBC_STEP_W_DEF,
    parameter int PRESC_W = UBC_PRESC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syn_clr,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      d,
    input  logic [N-1:0]      lo,
    input  logic [N-1:0]      hi,
    input  logic [STEP_W-1:0] step,
`ifdef UBC_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [N-1:0]      q,
    output logic              max_tick,
    output logic              min_tick,
    output logic              wrap_tick,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    logic [N-1:0] cnt_q, cnt_d;
    ubc_state_e   state_q, state_d;
    logic         wrap_q, wrap_d;

    ubc_mode_e    mode_e;
    logic         is_sat, is_oneshot;
    logic         presc_tick;
    logic         launch, count_ok, terminal;
    logic [N:0]   q_x, lo_x, hi_x, step_x, sum_x, lo_step_x;
    logic [N-1:0] step_n, advance, target;

`ifdef UBC_PRESCALE_EN
    ubc_prescaler #(
        .W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (syn_clr | load | start),
        .en    (en),
        .div   (presc),
        .tick  (presc_tick)
    );
`else
    // Without the divider every enabled cycle is a count cycle.
    assign presc_tick = (PRESC_W != 0);
`endif

    assign mode_e     = ubc_mode_e'(mode);
    assign is_sat     = (mode_e == MODE_SAT);
    assign is_oneshot = (mode_e == MODE_ONESHOT);
    assign cfg_err    = (lo > hi);

    // Bounds math in N+1 bits so q+step and lo+step cannot overflow.
    assign q_x       = {1'b0, cnt_q};
    assign lo_x      = {1'b0, lo};
    assign hi_x      = {1'b0, hi};
    assign step_x    = (N+1)'(step);
    assign step_n    = N'(step);
    assign sum_x     = q_x + step_x;
    assign lo_step_x = lo_x + step_x;

    assign terminal = up ? (sum_x > hi_x) : (q_x < lo_step_x);
    assign advance  = up ? sum_x[N-1:0] : (cnt_q - step_n);
    assign target   = (is_sat || is_oneshot) ? (up ? hi : lo) : (up ? lo : hi);

    assign launch   = is_oneshot && start && (state_q != ST_RUN);
    assign count_ok = en && presc_tick && !cfg_err && (step != '0)
                      && (!is_oneshot || (state_q == ST_RUN));

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (!is_oneshot) begin
            state_d = ST_IDLE;
        end
        if (syn_clr) begin
            cnt_d   = lo;
            state_d = ST_IDLE;
        end else if (load) begin
            cnt_d = d;
            if (launch) begin
                state_d = ST_RUN;
            end
        end else if (launch) begin
            cnt_d   = up ? lo : hi;
            state_d = ST_RUN;
        end else if (count_ok) begin
            if (terminal) begin
                cnt_d  = target;
                // A saturated counter pressing on its bound is not a new event
                wrap_d = is_sat ? (cnt_q != target) : 1'b1;
                if (is_oneshot) begin
                    state_d = ST_DONE;
                end
            end else begin
                cnt_d = advance;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q         = cnt_q;
    assign max_tick  = (cnt_q == hi);
    assign min_tick  = (cnt_q == lo);
    assign wrap_tick = wrap_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule
